// File: rtl/led_fade_bank.sv
// Bank of PWM LED channels with register-mapped targets and a slow linear
// fade engine that only moves brightness at PWM period boundaries.
module led_fade_bank #(
    parameter int         CHANNELS   = 4,
    parameter int         CTR_BITS   = 18,
    parameter logic [6:0] BASE_ADDR  = 7'h10,
    parameter logic [7:0] VERSION    = 8'h20,
    parameter bit         ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [6:0]          regnum,
    input  logic [7:0]          regdata_write,
    input  logic                write,
    output logic [7:0]          regdata_read,
    output logic [CHANNELS-1:0] led_out,
    output logic                period_tick
);

    localparam logic [CHANNELS-1:0] LED_OFF = {CHANNELS{ACTIVE_LOW}};

    logic [CTR_BITS-1:0] cnt;
    logic [7:0]          fade_cnt;
    logic [7:0]          fade_rate;
    logic                enable;
    logic [7:0]          target [CHANNELS];
    logic [7:0]          level  [CHANNELS];
    logic [CHANNELS-1:0] raw_pwm;
    logic [CHANNELS-1:0] led_q;
    logic [7:0]          status;

    logic       tick;
    logic       hit;
    logic [7:0] off;
    logic       wr_ctrl;
    logic       wr_rate;
    logic       fade_step;

    // Offset computed one bit wider so regnum below BASE_ADDR never aliases into the map.
    assign hit     = (regnum >= BASE_ADDR);
    assign off     = {1'b0, regnum} - {1'b0, BASE_ADDR};
    assign wr_ctrl = write && hit && (off == 8'd1);
    assign wr_rate = write && hit && (off == 8'd2);

    assign tick        = &cnt;
    assign period_tick = tick && !rst;
    assign fade_step   = (fade_rate != 8'd0) && (fade_cnt == fade_rate - 8'd1);

    function automatic logic [7:0] step_toward(input logic [7:0] lvl, input logic [7:0] tgt);
        if (lvl < tgt)
            return lvl + 8'd1;
        else if (lvl > tgt)
            return lvl - 8'd1;
        else
            return lvl;
    endfunction

    always_comb begin
        raw_pwm = '0;
        status  = 8'h00;
        for (int n = 0; n < CHANNELS; n++) begin
            raw_pwm[n] = (cnt[CTR_BITS-1 -: 8] < level[n]);
            status[n]  = (level[n] != target[n]);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: the target/level arrays are a handful of flops, so they are reset like any other state.
        if (rst) begin
            cnt       <= '0;
            fade_cnt  <= 8'd0;
            fade_rate <= 8'd0;
            enable    <= 1'b1;
            led_q     <= LED_OFF;
            for (int n = 0; n < CHANNELS; n++) begin
                target[n] <= 8'd0;
                level[n]  <= 8'd0;
            end
        end else begin
            cnt   <= cnt + CTR_BITS'(1);
            led_q <= ACTIVE_LOW ? ~(raw_pwm & {CHANNELS{enable}})
                                :  (raw_pwm & {CHANNELS{enable}});

            if (wr_ctrl)
                enable <= regdata_write[0];
            if (wr_rate)
                fade_rate <= regdata_write;

            // Level update reads the pre-edge target, so a coincident write lands next tick.
            for (int n = 0; n < CHANNELS; n++) begin
                if (write && hit && (off == 8'(4 + n)))
                    target[n] <= regdata_write;
                if (tick && enable) begin
                    if (fade_rate == 8'd0)
                        level[n] <= target[n];
                    else if (fade_step)
                        level[n] <= step_toward(level[n], target[n]);
                end
            end

            if (wr_rate)
                fade_cnt <= 8'd0;
            else if (tick && enable && (fade_rate != 8'd0))
                fade_cnt <= fade_step ? 8'd0 : fade_cnt + 8'd1;
        end
    end

    // Held inactive combinationally during reset so the first reset cycle is already dark.
    assign led_out = rst ? LED_OFF : led_q;

    always_comb begin
        regdata_read = 8'h00;
        if (hit) begin
            case (off)
                8'd0:    regdata_read = VERSION;
                8'd1:    regdata_read = {7'd0, enable};
                8'd2:    regdata_read = fade_rate;
                8'd3:    regdata_read = status;
                default: regdata_read = 8'h00;
            endcase
            for (int n = 0; n < CHANNELS; n++) begin
                if (off == 8'(4 + n))
                    regdata_read = target[n];
                if (off == 8'(4 + CHANNELS + n))
                    regdata_read = level[n];
            end
        end
    end

endmodule

// File: tb/tb_led_fade_bank.sv
// Directed bench for led_fade_bank: register map, PWM duty, fade stepping,
// enable freeze/resume and mid-fade reset, with hand-computed expectations.
module tb_led_fade_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] regnum;
    logic [7:0] regdata_write;
    logic       write;
    logic [7:0] regdata_read;
    logic [3:0] led_out;
    logic       period_tick;

    int vectors     = 0;
    int miscompares = 0;

    led_fade_bank #(
        .CHANNELS  (4),
        .CTR_BITS  (10),
        .BASE_ADDR (7'h10),
        .VERSION   (8'h20),
        .ACTIVE_LOW(1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .regnum       (regnum),
        .regdata_write(regdata_write),
        .write        (write),
        .regdata_read (regdata_read),
        .led_out      (led_out),
        .period_tick  (period_tick)
    );

    always #50 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic read_check(input string tag, input logic [6:0] addr, input logic [7:0] expected);
        regnum = addr;
        #1;
        check(tag, {8'h00, regdata_read}, {8'h00, expected});
    endtask

    task automatic write_reg(input logic [6:0] addr, input logic [7:0] data);
        @(negedge clk);
        regnum        = addr;
        regdata_write = data;
        write         = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    // Returns on the negedge inside a period_tick cycle; a missing tick is a failed comparison.
    task automatic wait_tick(input string tag);
        int n = 0;
        while (period_tick !== 1'b1 && n < 1100) begin
            @(negedge clk);
            n++;
        end
        check(tag, {15'd0, period_tick}, 16'd1);
    endtask

    // Counts cycles over one full period in which led_out[ch] equals val.
    task automatic count_led(input int ch, input logic val, output int cnt);
        cnt = 0;
        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            if (led_out[ch] === val)
                cnt++;
        end
    endtask

    initial begin
        int n;
        int lows;
        rst           = 1'b1;
        regnum        = 7'h00;
        regdata_write = 8'h00;
        write         = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_led", {12'd0, led_out}, 16'h000f);
        check("rst_tick", {15'd0, period_tick}, 16'd0);
        rst = 1'b0;
        n = 0;
        while (period_tick !== 1'b1 && n < 1100) begin
            @(negedge clk);
            n++;
        end
        check("first_tick_delay", 16'(n), 16'd1023);
        read_check("version", 7'h10, 8'h20);
        read_check("control", 7'h11, 8'h01);
        read_check("rate_rst", 7'h12, 8'h00);
        read_check("status_rst", 7'h13, 8'h00);
        read_check("unmapped_7f", 7'h7F, 8'h00);
        read_check("unmapped_1c", 7'h1C, 8'h00);
        read_check("below_base", 7'h0F, 8'h00);
        read_check("level0_rst", 7'h18, 8'h00);
        check("led_idle", {12'd0, led_out}, 16'h000f);

        // Immediate load with FADE_RATE=0, plus RO writes ignored
        write_reg(7'h14, 8'h80);
        write_reg(7'h18, 8'h55);
        write_reg(7'h10, 8'h00);
        read_check("target0", 7'h14, 8'h80);
        read_check("level0_pre", 7'h18, 8'h00);
        read_check("version_ro", 7'h10, 8'h20);
        read_check("status_pend0", 7'h13, 8'h01);
        wait_tick("tick_load");
        read_check("level0_at_tick", 7'h18, 8'h00);
        @(negedge clk);
        read_check("level0_loaded", 7'h18, 8'h80);
        read_check("status_load", 7'h13, 8'h00);
        count_led(0, 1'b0, lows);
        check("duty_80_low", 16'(lows), 16'd512);

        // FADE_RATE=2: one step per two ticks
        write_reg(7'h12, 8'h02);
        write_reg(7'h15, 8'h03);
        read_check("rate2", 7'h12, 8'h02);
        read_check("status_fade1", 7'h13, 8'h02);
        for (int s = 1; s <= 3; s++) begin
            wait_tick("tick_r2a");
            @(negedge clk);
            read_check("level1_hold", 7'h19, 8'(s - 1));
            wait_tick("tick_r2b");
            @(negedge clk);
            read_check("level1_step", 7'h19, 8'(s));
            read_check("status_r2", 7'h13, (s == 3) ? 8'h00 : 8'h02);
        end

        // Redirected fade on channel 2 with FADE_RATE=1
        write_reg(7'h12, 8'h01);
        write_reg(7'h16, 8'h10);
        for (int s = 1; s <= 5; s++) begin
            wait_tick("tick_up");
            @(negedge clk);
            read_check("level2_up", 7'h1A, 8'(s));
        end
        write_reg(7'h16, 8'h00);
        read_check("level2_nojump", 7'h1A, 8'h05);
        for (int s = 4; s >= 0; s--) begin
            wait_tick("tick_down");
            @(negedge clk);
            read_check("level2_down", 7'h1A, 8'(s));
        end
        read_check("status_down", 7'h13, 8'h00);
        count_led(2, 1'b1, lows);
        check("level0_led_high", 16'(lows), 16'd1024);

        // Enable freeze and resume on channel 3
        write_reg(7'h17, 8'h20);
        for (int s = 1; s <= 3; s++) begin
            wait_tick("tick_en");
            @(negedge clk);
        end
        read_check("level3_pre", 7'h1B, 8'h03);
        write_reg(7'h11, 8'h00);
        @(negedge clk);
        read_check("control_off", 7'h11, 8'h00);
        check("led_disabled", {12'd0, led_out}, 16'h000f);
        count_led(0, 1'b1, lows);
        check("led0_off_period", 16'(lows), 16'd1024);
        wait_tick("tick_frz");
        @(negedge clk);
        read_check("level3_frozen", 7'h1B, 8'h03);
        write_reg(7'h17, 8'h21);
        read_check("target3_while_off", 7'h17, 8'h21);
        write_reg(7'h11, 8'h01);
        wait_tick("tick_res1");
        @(negedge clk);
        read_check("level3_resume1", 7'h1B, 8'h04);
        wait_tick("tick_res2");
        @(negedge clk);
        read_check("level3_resume2", 7'h1B, 8'h05);

        // Mid-fade reset
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst2_led", {12'd0, led_out}, 16'h000f);
        check("rst2_tick", {15'd0, period_tick}, 16'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            read_check("rst2_target", 7'(8'h14 + c), 8'h00);
            read_check("rst2_level", 7'(8'h18 + c), 8'h00);
        end
        read_check("rst2_rate", 7'h12, 8'h00);
        read_check("rst2_control", 7'h11, 8'h01);
        read_check("rst2_status", 7'h13, 8'h00);
        wait_tick("tick_post1");
        @(negedge clk);
        wait_tick("tick_post2");
        @(negedge clk);
        read_check("rst2_level3_still", 7'h1B, 8'h00);
        check("rst2_led_idle", {12'd0, led_out}, 16'h000f);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
